// File: rtl/itch_pkg.sv
// Shared ITCH definitions: framer state encoding, message type codes and
// payload field offsets.
package itch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DISCARD = 2'd2
   } state_t;

   localparam logic [7:0] ITCH_TYPE_ADD       = 8'h41;
   localparam logic [7:0] ITCH_TYPE_DELETE    = 8'h44;
   localparam logic [7:0] ITCH_TYPE_EXECUTED  = 8'h45;
   localparam logic [7:0] ITCH_TYPE_SYSTEM    = 8'h53;

   localparam int unsigned STOCK_LOCATE_OFS = 0;

endpackage

// File: rtl/itch_byte_counter.sv
// Payload byte counter: cleared on header accept, advanced per consumed byte,
// flags the final byte of the message (count == len-1).
module itch_byte_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign last = (count == (len - CNT_W'(1)));

endmodule

// File: rtl/itch_payload_framer.sv
// Frames ITCH message payloads following a header pulse: tags bytes with
// type/sop/eop/index, captures stock locate, discards bad-length messages.
module itch_payload_framer
   import itch_pkg::*;
#(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [7:0]  hdr_type,
   input  logic [15:0] hdr_len,
   input  logic        hdr_valid,
   output logic [7:0]  pl_data,
   output logic        pl_valid,
   output logic        pl_sop,
   output logic        pl_eop,
   output logic [15:0] pl_idx,
   output logic [7:0]  pl_type,
   output logic [15:0] stock_locate,
   output logic        msg_done,
   output logic        err_oversize,
   output logic        err_zero_len,
   output logic        err_overlap,
   output logic        busy
);

   state_t           state, state_n;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             hdr_zero, hdr_big, hdr_take, byte_take;

   logic [7:0]  pl_data_n, pl_type_n;
   logic [15:0] pl_idx_n, stock_locate_n;
   logic        pl_valid_n, pl_sop_n, pl_eop_n, msg_done_n;
   logic        err_oversize_n, err_zero_len_n, err_overlap_n, busy_n;

   assign hdr_zero  = (hdr_len == 16'd0);
   assign hdr_big   = (32'(hdr_len) > MAX_LEN);
   assign hdr_take  = (state == IDLE) && hdr_valid && !hdr_zero;
   assign byte_take = (state != IDLE) && rx_valid;

   itch_byte_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (hdr_take),
      .enable (byte_take),
      .len    (len_q),
      .count  (cnt),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         len_q <= '0;
      end else begin
         state <= state_n;
         if (hdr_take)
            len_q <= CNT_W'(hdr_len);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (hdr_valid && !hdr_zero)
               state_n = hdr_big ? DISCARD : PAYLOAD;
         end
         PAYLOAD, DISCARD: begin
            if (rx_valid && cnt_last)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      pl_data_n      = '0;
      pl_valid_n     = 1'b0;
      pl_sop_n       = 1'b0;
      pl_eop_n       = 1'b0;
      pl_idx_n       = '0;
      pl_type_n      = pl_type;
      stock_locate_n = stock_locate;
      msg_done_n     = 1'b0;
      err_oversize_n = 1'b0;
      err_zero_len_n = (state == IDLE) && hdr_valid && hdr_zero;
      err_overlap_n  = (state != IDLE) && hdr_valid;
      busy_n         = (state_n != IDLE);
      if (hdr_take) begin
         err_oversize_n = hdr_big;
         if (!hdr_big)
            pl_type_n = hdr_type;
      end
      if (state == PAYLOAD && rx_valid) begin
         pl_data_n  = rx_data;
         pl_valid_n = 1'b1;
         pl_idx_n   = 16'(cnt);
         pl_sop_n   = (cnt == '0);
         pl_eop_n   = cnt_last;
         msg_done_n = cnt_last;
         // Byte 0 also clears the low half so a 1-byte message leaves it 0.
         if (cnt == CNT_W'(STOCK_LOCATE_OFS))
            stock_locate_n = {rx_data, 8'h00};
         else if (cnt == CNT_W'(STOCK_LOCATE_OFS + 1))
            stock_locate_n = {stock_locate[15:8], rx_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pl_data      <= '0;
         pl_valid     <= 1'b0;
         pl_sop       <= 1'b0;
         pl_eop       <= 1'b0;
         pl_idx       <= '0;
         pl_type      <= '0;
         stock_locate <= '0;
         msg_done     <= 1'b0;
         err_oversize <= 1'b0;
         err_zero_len <= 1'b0;
         err_overlap  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         pl_data      <= pl_data_n;
         pl_valid     <= pl_valid_n;
         pl_sop       <= pl_sop_n;
         pl_eop       <= pl_eop_n;
         pl_idx       <= pl_idx_n;
         pl_type      <= pl_type_n;
         stock_locate <= stock_locate_n;
         msg_done     <= msg_done_n;
         err_oversize <= err_oversize_n;
         err_zero_len <= err_zero_len_n;
         err_overlap  <= err_overlap_n;
         busy         <= busy_n;
      end
   end

endmodule
